// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block as sixteen 32-bit words
// into a sliding 16-word window. It then emits W[0..63], one word per enabled
// clock, together with the round index for the compression stage.
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    input  logic        round_en,
    output logic [31:0] out_w,
    output logic [5:0]  out_k_num,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  t_q, t_d;

    logic        shift_en;
    logic [31:0] fill_word;
    logic [31:0] next_w;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Next schedule word from the current window (win[0] holds W[t]).
    always_comb begin
        next_w = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end

    // Next-state logic. The window shifts down by one place either to take a
    // loaded word or to take a freshly expanded one. The last round does not
    // shift, so no word past W63 is ever produced.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        shift_en   = 1'b0;
        fill_word  = 32'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_cnt_d = 4'd0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    shift_en   = 1'b1;
                    fill_word  = in_word;
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d = RUN;
                        t_d     = 6'd0;
                    end
                end
            end
            RUN: begin
                if (round_en) begin
                    if (t_q == LAST_T) begin
                        state_d = DONE;
                    end else begin
                        shift_en  = 1'b1;
                        fill_word = next_w;
                        t_d       = t_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = fill_word;
        end
    end

    // State, window and counters; reset discards any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= 4'd0;
            t_q        <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Outputs come straight from registers or from a decode of the state.
    always_comb begin
        out_w     = win_q[0];
        out_k_num = t_q;
        out_valid = (state_q == RUN);
        busy      = (state_q == LOAD) || (state_q == RUN);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule. A block-level reference model
// expands each loaded block with the textbook W[t] recurrence. A negedge
// compare process checks the DUT against that model on every cycle.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t   [16];
    typedef logic [31:0] sched_t [64];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        in_valid = 1'b0;
    logic        round_en = 1'b0;
    logic [31:0] out_w;
    logic [5:0]  out_k_num;
    logic        out_valid;
    logic        busy;
    logic        done;

    int     err_cnt = 0;
    int     chk_cnt = 0;
    int     done_cnt = 0;
    bit     chk_en = 1'b0;
    time    done_t_prev = 0;
    time    done_t_last = 0;

    // Reference model state: phase 0 idle, 1 loading, 2 running, 3 done.
    int     m_phase = 0;
    int     m_cnt = 0;
    int     m_t = 0;
    blk_t   m_msg;
    sched_t m_sched;
    blk_t   m_tmp;

    sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .round_en  (round_en),
        .out_w     (out_w),
        .out_k_num (out_k_num),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    function automatic sched_t expand(input blk_t msg);
        sched_t w;
        for (int t = 0; t < 16; t++) w[t] = msg[t];
        for (int t = 16; t < 64; t++)
            w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus: drive inputs now, hold them across the next edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [31:0] w, input logic r);
        start    = s;
        in_valid = v;
        in_word  = w;
        round_en = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model tracks what the block must be doing at every edge.
    always @(posedge clk or posedge rst) begin : model_proc
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_t     <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_cnt   <= 0;
                end
                1: if (in_valid) begin
                    m_msg[m_cnt] <= in_word;
                    m_cnt        <= m_cnt + 1;
                    if (m_cnt == 15) begin
                        m_tmp     = m_msg;
                        m_tmp[15] = in_word;
                        m_sched  <= expand(m_tmp);
                        m_phase  <= 2;
                        m_t      <= 0;
                    end
                end
                2: if (round_en) begin
                    if (m_t == 63) m_phase <= 3;
                    else           m_t <= m_t + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Compare the DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            checkOutput("busy", {31'd0, busy}, {31'd0, (m_phase == 1) || (m_phase == 2)});
            checkOutput("done", {31'd0, done}, {31'd0, m_phase == 3});
            if (m_phase == 2) begin
                checkOutput("out_w", out_w, m_sched[m_t]);
                checkOutput("out_k_num", {26'd0, out_k_num}, 32'(m_t));
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t_prev = done_t_last;
                done_t_last = $time;
            end
        end
    end

    // Start, load and run one block. mode 0: round_en held high,
    // mode 1: random round_en with 10-cycle stalls at t=15,16,63,
    // mode 2: start/in_valid pulsed during RUN. stop_t >= 0 abandons the
    // run at that round (left in RUN). gap inserts idle cycles into the load.
    task automatic do_block(input blk_t msg, input bit gap, input int mode, input int stop_t);
        int       cyc;
        int       stall_left;
        bit [63:0] stalled;
        logic     r;
        if (gap) applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        else     applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (gap && (i % 3 == 1)) begin
                applyStimulus(1'b1, 1'b0, 32'hBAD0BAD0, 1'b0);
                applyStimulus(1'b0, 1'b0, 32'h0BADF00D, 1'b1);
            end
            applyStimulus(1'b0, 1'b1, msg[i], 1'b0);
        end
        cyc = 0;
        stall_left = 0;
        stalled = '0;
        while (m_phase == 2 && cyc < 1000 && !(stop_t >= 0 && m_t == stop_t)) begin
            if (mode == 1 && (m_t inside {15, 16, 63}) && !stalled[m_t]) begin
                stalled[m_t] = 1'b1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
            end
            if (mode == 2 && cyc % 5 == 2) applyStimulus(1'b1, 1'b1, $urandom, r);
            else                           applyStimulus(1'b0, 1'b0, 32'd0, r);
            cyc++;
        end
        if (cyc >= 1000) begin
            chk_cnt++;
            err_cnt++;
            $display("[TB] FAIL run_bound: got %0d cycles, expected under 1000", cyc);
        end
        if (m_phase == 3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        checkOutput({tag, "_out_w"}, out_w, 32'd0);
        checkOutput({tag, "_out_k_num"}, {26'd0, out_k_num}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        blk_t abc;
        blk_t ffb;
        for (int i = 0; i < 16; i++) begin
            abc[i] = 32'd0;
            ffb[i] = 32'hFFFFFFFF;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        #1 rst = 1'b1;
        #2 check_zero_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b1);

        // NIST "abc" block, round_en held high.
        do_block(abc, 1'b0, 0, -1);
        checkOutput("model_abc_w16", m_sched[16], 32'h61626380);
        checkOutput("model_abc_w17", m_sched[17], 32'h000F0000);
        checkOutput("done_count_1", 32'(done_cnt), 32'd1);

        // Same block with random and forced stalls.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        do_block(abc, 1'b0, 1, -1);
        checkOutput("done_count_2", 32'(done_cnt), 32'd2);

        // Gapped load plus start/in_valid during RUN.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        do_block(abc, 1'b1, 2, -1);
        checkOutput("done_count_3", 32'(done_cnt), 32'd3);

        // Abort at t=30 with an asynchronous mid-cycle reset.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        do_block(abc, 1'b0, 0, 30);
        checkOutput("abort_t", {26'd0, out_k_num}, 32'd30);
        start = 1'b0;
        in_valid = 1'b0;
        round_en = 1'b0;
        #3 rst = 1'b1;
        #1 check_zero_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        do_block(ffb, 1'b0, 0, -1);
        checkOutput("model_ff_w16", m_sched[16], 32'h203FFFFC);
        checkOutput("done_count_4", 32'(done_cnt), 32'd4);

        // Back-to-back blocks: second start in the cycle right after done.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        do_block(abc, 1'b0, 0, -1);
        do_block(ffb, 1'b0, 0, -1);
        checkOutput("done_count_6", 32'(done_cnt), 32'd6);
        checkOutput("b2b_period", 32'((done_t_last - done_t_prev) / 10), 32'd82);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Message-schedule stage of the SHA-256 ASIC, directly upstream of `main_block`. It accepts one 512-bit block as sixteen 32-bit words and expands it into the 64-word schedule W[0..63]. It emits W[t] together with the round index t, which `main_block` consumes on its `in_w` and `k_num` inputs. One word is produced per enabled clock, so the compression rounds can run back-to-back.

## Interface
- `NUM_ROUNDS`, 64, schedule length; fixed by SHA-256, never overridden.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle pulse; begins loading a new block when idle.
- `in_word`  input  32  message word, word 0 first, big-endian as per FIPS 180-4.
- `in_valid`  input  1  `in_word` is valid this cycle (honoured only in LOAD).
- `round_en`  input  1  consumer took the current W[t]; advance to t+1.
- `out_w`  output  32  current schedule word W[t], registered.
- `out_k_num`  output  6  current round index t, registered.
- `out_valid`  output  1  `out_w` / `out_k_num` are meaningful.
- `busy`  output  1  high in LOAD and RUN.
- `done`  output  1  one-cycle pulse after W[63] has been consumed.

## Operation
- The block has four states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `start`=1 → LOAD, with the load counter cleared.
  - `in_valid` is ignored.
- **LOAD**
  - Each cycle with `in_valid`=1 shifts `in_word` into the 16-entry window `win[15]` and increments the load counter (4 bits).
  - The 16th word moves the state to RUN. `win[0]`=W0 … `win[15]`=W15.
  - Cycles with `in_valid`=0 hold state; there is no timeout.
- **RUN**
  - `out_w`=`win[0]`, `out_k_num`=t, `out_valid`=1.
  - On `round_en`=1 the window shifts down one place (`win[i]`←`win[i+1]`) and `win[15]` ← σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]`.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All additions are mod 2^32; carries are discarded.
  - The index t increments with each shift.
  - `round_en`=1 while t=63 → DONE. The window contents are don't-care at that point.
  - `round_en`=0 holds every register; the stall may last any length.
- **DONE**
  - `done`=1 and `out_valid`=0 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. There is no restart mid-block; `rst` is the only abort.
- Words produced past t=63 are never computed or emitted.

## Timing
- Reset values: `out_w`=0, `out_k_num`=0, `out_valid`=0, `busy`=0, `done`=0, state=IDLE, window=0, counters=0.
- Reset mid-LOAD or mid-RUN forces the reset values asynchronously; the partial block is discarded.
- Latency:
  - `start` at edge N → `busy`=1 after edge N.
  - The 16th `in_valid` at edge M → W0 on `out_w` with `out_valid`=1 after edge M.
- Throughput: with `round_en` held high, W0..W63 appear on 64 consecutive cycles.
- `done` is high the cycle after the edge that consumes W63. `busy` falls on that same edge.
- Minimum block period: 1 (start) + 16 (load) + 64 (run) + 1 (done) = 82 cycles.
- `in_valid` and `start` in the same IDLE cycle: only `start` is taken; the word is dropped.
- `round_en` outside RUN has no effect.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs read 0 immediately. Release, then idle 5 cycles → `out_valid`=0 and `busy`=0 throughout.
- **NIST "abc" block:** load W0=61626380, W1..W14=00000000, W15=00000018 with `round_en`=1 → expected sequence:
  - t=0..15 echo the loaded words.
  - W16=61626380, W17=000F0000.
  - All 64 words match a reference model.
  - `out_k_num` counts 0..63.
  - `done` pulses once, on the cycle after t=63.
- **Stalls:** same block with `round_en` toggling randomly and held low for 10 cycles at t=15, 16 and 63 → identical word sequence, no skipped or repeated t, and `out_w` stable while stalled.
- **Load gaps and ignored inputs:**
  - `in_valid` gapped between loaded words → same result as the gap-free load.
  - `start` pulsed during RUN → no effect.
  - `in_valid` during RUN → the window is unchanged.
- **Reset mid-operation:** assert `rst` at t=30, then load a second block of all-FFFFFFFF words → outputs restart at t=0 with W0=FFFFFFFF. W16 equals the mod-2^32 model value, with no leftover state from the aborted block.
- **Back-to-back blocks:** `start` the cycle after `done` → the second block completes in exactly 82 cycles, `done` pulses once per block, and the output words match the model for both blocks.
